// File: rtl/hex_scan_display.sv
// Time-multiplexed driver for a common-anode 8-digit seven-segment display, with a per-frame digit snapshot and a blanking guard between digits.
// Optional: define HEX_SCAN_LZ_BLANK_EN to suppress leading zeros (digits 7..1) in the snapshot.
module hex_scan_display #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic [7:0]  GUARD    = 8'd4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Din0,
    input  logic [3:0] Din1,
    input  logic [3:0] Din2,
    input  logic [3:0] Din3,
    input  logic [3:0] Din4,
    input  logic [3:0] Din5,
    input  logic [3:0] Din6,
    input  logic [3:0] Din7,
    output logic [7:0] An,
    output logic [6:0] Seg,
    output logic       Frame_done
);
    localparam int unsigned SCAN_N     = 32'(SCAN_DIV);
    localparam int unsigned GUARD_N    = 32'(GUARD);
    localparam int unsigned SCAN_W     = $clog2(SCAN_N);
    localparam int unsigned GUARD_W    = $clog2(GUARD_N);
    localparam int unsigned CNT_W0     = (SCAN_W > GUARD_W) ? SCAN_W : GUARD_W;
    localparam int unsigned CNT_W      = (CNT_W0 > 1) ? CNT_W0 : 1;
    localparam int unsigned SCAN_LAST  = SCAN_N - 1;
    localparam int unsigned GUARD_LAST = (GUARD_N == 0) ? 0 : GUARD_N - 1;
    localparam bit          HAS_GUARD  = (GUARD_N != 0);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // With no guard the blank state does not exist, so the scan starts in DRIVE.
    localparam state_t RST_STATE = HAS_GUARD ? ST_BLANK : ST_DRIVE;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         din     [8];
    logic [3:0]         snap_q  [8];
    logic [3:0]         view    [8];
    logic               snap_now;
    logic [7:0]         an_d;
    logic [6:0]         seg_d;
    logic               fd_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb begin
        din = '{Din0, Din1, Din2, Din3, Din4, Din5, Din6, Din7};
    end

    // First cycle of digit 0's slot; the live inputs stand in for the snapshot being captured.
    always_comb begin
        snap_now = (idx_q == 3'd0) && (cnt_q == '0) && (state_q == RST_STATE);
        for (int i = 0; i < 8; i++) begin
            view[i] = snap_now ? din[i] : snap_q[i];
        end
    end

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= RST_STATE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (state_q == ST_BLANK) begin
            if (cnt_q == CNT_W'(GUARD_LAST)) begin
                state_d = ST_DRIVE;
                cnt_d   = '0;
            end
        end else begin
            if (cnt_q == CNT_W'(SCAN_LAST)) begin
                state_d = HAS_GUARD ? ST_BLANK : ST_DRIVE;
                idx_d   = idx_q + 3'd1;
                cnt_d   = '0;
            end
        end
    end

`ifdef HEX_SCAN_LZ_BLANK_EN
    logic [7:0] lz_blank;

    // Digit i is a leading zero when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        lz_blank    = 8'h00;
        lz_blank[7] = (view[7] == 4'h0);
        for (int i = 6; i >= 1; i--) begin
            lz_blank[i] = lz_blank[i+1] && (view[i] == 4'h0);
        end
    end
`endif

    // Output logic, registered below
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        fd_d  = 1'b0;
        if (state_q == ST_DRIVE) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex_to_seg(view[idx_q]);
            fd_d  = (idx_q == 3'd7) && (cnt_q == CNT_W'(SCAN_LAST));
`ifdef HEX_SCAN_LZ_BLANK_EN
            if (lz_blank[idx_q]) begin
                an_d  = 8'hFF;
                seg_d = 7'h7F;
            end
`endif
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            An         <= 8'hFF;
            Seg        <= 7'h7F;
            Frame_done <= 1'b0;
        end else begin
            An         <= an_d;
            Seg        <= seg_d;
            Frame_done <= fd_d;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            snap_q <= '{default: 4'h0};
        end else if (snap_now) begin
            for (int i = 0; i < 8; i++) begin
                snap_q[i] <= din[i];
            end
        end
    end

endmodule
